// File: rtl/fp_adder_pkg.sv
// fp_adder_pkg: widths and exception flag layout shared across the FP adder pipeline.
package fp_adder_pkg;
    localparam int FP_W           = 32;
    localparam int FLAG_W         = 4;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;
    typedef logic [FLAG_W-1:0] fp_flags_t;
    typedef struct packed {
        fp_flags_t         flags;
        logic [FP_W-1:0]   data;
    } fp_result_t;
endpackage

// File: rtl/fp_result_out_if.sv
// fp_result_out_if: result intake, downstream output and sticky-flag readback of the adder output stage.
interface fp_result_out_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = fp_adder_pkg::FP_W,
    parameter int FLAG_W = fp_adder_pkg::FLAG_W
);
    logic                       res_valid;
    logic                       res_ready;
    logic [DATA_W-1:0]          res_data;
    logic [FLAG_W-1:0]          res_flags;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [FLAG_W-1:0]          out_flags;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic [FLAG_W-1:0]          sticky_flags;
    logic                       sticky_clr;
    modport slave (
        input  res_valid, res_data, res_flags, out_ready, sticky_clr,
        output res_ready, out_valid, out_data, out_flags, level, sticky_flags
    );
    modport master (
        output res_valid, res_data, res_flags, out_ready, sticky_clr,
        input  res_ready, out_valid, out_data, out_flags, level, sticky_flags
    );
endinterface

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: first-word-fall-through storage; occupancy is tracked by level, pointers wrap modulo DEPTH.
module fp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [$clog2(DEPTH+1)-1:0] level_d_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic          push_ok, pop_ok;
    assign push_ok   = push_i & (level_q != LW'(DEPTH));
    assign pop_ok    = pop_i & (level_q != '0);
    assign level_d_o = level_q + LW'(push_ok) - LW'(pop_ok);
    assign level_o   = level_q;
    assign empty_o   = level_q == '0;
    assign rdata_o   = mem_q[rptr_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) mem_q[wptr_q] <= wdata_i;
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok) rptr_q <= rptr_q + AW'(1);
            level_q <= level_d_o;
        end
    end
endmodule

// File: rtl/fp_result_out.sv
// fp_result_out: buffers adder results with their flags, hands them downstream via valid/ready,
// and accumulates sticky exception flags for software.
module fp_result_out #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = fp_adder_pkg::FP_W,
    parameter int FLAG_W = fp_adder_pkg::FLAG_W
) (
    input  logic            clk,
    input  logic            reset,
    fp_result_out_if.slave  bus
);
    localparam int LW = $clog2(DEPTH+1);
    logic                     push, pop, empty, res_ready_q;
    logic [LW-1:0]            level_d;
    logic [DATA_W+FLAG_W-1:0] head;
    logic [FLAG_W-1:0]        sticky_q, sticky_d;
    assign push = bus.res_valid & res_ready_q;
    assign pop  = ~empty & bus.out_ready;
    fp_sync_fifo #(.DEPTH(DEPTH), .W(DATA_W+FLAG_W)) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   ({bus.res_flags, bus.res_data}),
        .rdata_o   (head),
        .level_o   (bus.level),
        .level_d_o (level_d),
        .empty_o   (empty)
    );
    // clear takes effect before the incoming flags are merged
    always_comb sticky_d = (bus.sticky_clr ? '0 : sticky_q) | (push ? bus.res_flags : '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            res_ready_q <= 1'b0;
            sticky_q    <= '0;
        end else begin
            res_ready_q <= level_d != LW'(DEPTH);
            sticky_q    <= sticky_d;
        end
    end
    assign bus.res_ready    = res_ready_q;
    assign bus.out_valid    = ~empty;
    assign bus.out_data     = empty ? '0 : head[DATA_W-1:0];
    assign bus.out_flags    = empty ? '0 : head[DATA_W+:FLAG_W];
    assign bus.sticky_flags = sticky_q;
endmodule
